// File: rtl/instr_fetch.sv
// instr_fetch: fetch sequencer on the read side of the instruction memory.
// Drives pointer/read strobe, waits MEM_LATENCY cycles, captures the word and
// offers it to the execution engine. The PC advances sequentially or follows
// a jump taken at the handshake. The run ends at end-of-memory or on an
// out-of-range jump (fault).
//
// Handshake: a word is transferred on any rising clk edge where instr_valid
// and instr_ready are both 1. instr_valid never drops and instr/pc never
// change until that transfer happens (or abort/reset). jump_en/jump_addr are
// only looked at on the transfer edge.
module instr_fetch #(
  parameter int DEPTH       = 10,
  parameter int ADDR_W      = 4,
  parameter int INSTR_W     = 26,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  pointer,
  output logic               read_data,
  output logic               write_data,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               done,
  output logic               fault,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Latency is 1..4, so the remaining-wait counter only needs 0..3.
  localparam int                CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  // One extra bit so pc+1 from DEPTH-1 is compared before any wrap.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n, done_n, fault_n;
  logic [ADDR_W:0]    seq_next;
  logic [ADDR_W:0]    jump_x;

  assign seq_next   = {1'b0, pc} + (ADDR_W + 1)'(1);
  assign jump_x     = {1'b0, jump_addr};
  assign write_data = 1'b0;
  assign state_dbg  = state;

  // Next-state and next-output decode; abort overrides every state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    instr_n = instr;
    valid_n = instr_valid;
    done_n  = done;
    fault_n = fault;
    if (abort) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      done_n  = 1'b0;
      fault_n = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_n    = '0;
            done_n  = 1'b0;
            fault_n = 1'b0;
            state_n = S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_n   = CNT_LOAD;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            instr_n = mem_data;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (instr_valid && instr_ready) begin
            valid_n = 1'b0;
            if (jump_en) begin
              if (jump_x < DEPTH_X) begin
                pc_n    = jump_addr;
                state_n = S_ISSUE;
              end else begin
                // Illegal target: pc keeps the last legal address.
                done_n  = 1'b1;
                fault_n = 1'b1;
                state_n = S_DONE;
              end
            end else if (seq_next < DEPTH_X) begin
              pc_n    = seq_next[ADDR_W-1:0];
              state_n = S_ISSUE;
            end else begin
              done_n  = 1'b1;
              fault_n = 1'b0;
              state_n = S_DONE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and output registers; the read strobe is high exactly in ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc          <= '0;
      pointer     <= '0;
      read_data   <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      pointer     <= pc_n;
      read_data   <= (state_n == S_ISSUE);
      instr       <= instr_n;
      instr_valid <= valid_n;
      done        <= done_n;
      fault       <= fault_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a MEM_LATENCY=1 instance driven through reset,
// sequential, backpressure, jump, self-loop and illegal-jump runs with a
// queue-based scoreboard, plus a MEM_LATENCY=3 instance for abort/latency.
module tb_instr_fetch;

  localparam int W = 30;  // {pc[3:0], instr[25:0]}
  localparam logic [25:0] GARBAGE = 26'h2dead00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- latency-1 instance ----------------
  logic        start = 0, abort = 0, ready = 0, jump_en = 0;
  logic [3:0]  jump_addr = 0;
  logic [3:0]  ptr, pc;
  logic        rd, wr, valid, done, fault;
  logic [25:0] mem_data, instr;
  logic [2:0]  st;

  instr_fetch #(.DEPTH(10), .ADDR_W(4), .INSTR_W(26), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pointer(ptr), .read_data(rd), .write_data(wr), .mem_data(mem_data),
    .instr(instr), .instr_valid(valid), .instr_ready(ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .pc(pc),
    .done(done), .fault(fault), .state_dbg(st)
  );

  // ---------------- latency-3 instance ----------------
  logic        start_3 = 0, abort_3 = 0, ready_3 = 0, jump_en_3 = 0;
  logic [3:0]  jump_addr_3 = 0;
  logic [3:0]  ptr_3, pc_3;
  logic        rd_3, wr_3, valid_3, done_3, fault_3;
  logic [25:0] mem_data_3, instr_3;
  logic [2:0]  st_3;

  instr_fetch #(.DEPTH(10), .ADDR_W(4), .INSTR_W(26), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start_3), .abort(abort_3),
    .pointer(ptr_3), .read_data(rd_3), .write_data(wr_3), .mem_data(mem_data_3),
    .instr(instr_3), .instr_valid(valid_3), .instr_ready(ready_3),
    .jump_en(jump_en_3), .jump_addr(jump_addr_3), .pc(pc_3),
    .done(done_3), .fault(fault_3), .state_dbg(st_3)
  );

  // ---------------- memory models ----------------
  logic [25:0] mem [10];
  logic [25:0] p3 [3];
  initial for (int k = 0; k < 10; k++) mem[k] = 26'h100 + 26'(k);

  // Data appears one edge after the strobe edge; garbage otherwise.
  always @(posedge clk) mem_data <= rd ? mem[ptr] : GARBAGE;

  // Three-stage delay for the latency-3 instance.
  always @(posedge clk) begin
    p3[0] <= rd_3 ? mem[ptr_3] : GARBAGE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_data_3 = p3[2];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_fetch(input int a);
    logic [3:0] av;
    av = 4'(a);
    rd_q.push_back(av);
    exp_q.push_back({av, 26'h100 + 26'(a)});
  endtask

  // Monitor: every handshake and every read strobe is matched against the queues.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [3:0]   p;
    if (reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_handshake: got pc=%0d instr=%0h, required none", pc, instr);
      end else begin
        e = exp_q.pop_front();
        check("handshake_instr", 32'(instr), 32'(e[25:0]));
        check("handshake_pc", 32'(pc), 32'(e[29:26]));
      end
    end
    if (reset && rd) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got pointer=%0d, required no read", ptr);
      end else begin
        p = rd_q.pop_front();
        check("read_pointer", 32'(ptr), 32'(p));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold(input logic [3:0] p);
    int n;
    for (n = 0; n < 60; n++) begin
      if (st == 3'd3 && pc == p) break;
      tick();
    end
    n_checks++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL wait_hold: pc=%0d never reached HOLD, required within 60 cycles", p);
    end
  endtask

  task automatic wait_done(output int n);
    for (n = 0; n < 60; n++) begin
      if (done) break;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset state.
    reset = 0;
    tick(); tick();
    check("rst_state", 32'(st), 0);
    check("rst_pointer", 32'(ptr), 0);
    check("rst_read", 32'(rd), 0);
    check("rst_write", 32'(wr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_done_fault", {30'd0, done, fault}, 0);
    reset = 1;
    tick();

    // Mid-stream reset while holding a word.
    ready = 0;
    rd_q.push_back(4'd0);
    start = 1; tick(); start = 0;
    tick(); tick();
    check("hold_before_reset_valid", 32'(valid), 1);
    check("hold_before_reset_instr", 32'(instr), 32'h100);
    reset = 0;
    tick(); tick();
    check("midrst_state", 32'(st), 0);
    check("midrst_instr", 32'(instr), 0);
    check("midrst_valid_read", {30'd0, valid, rd}, 0);
    check("midrst_pointer", 32'(ptr), 0);
    reset = 1;
    tick();

    // Sequential run, ready held high: done 30 cycles after start.
    ready = 1;
    for (int k = 0; k < 10; k++) expect_fetch(k);
    start = 1; tick(); start = 0;
    wait_done(n);
    check("seq_done_latency", 32'(n), 30);
    check("seq_fault", 32'(fault), 0);
    check("seq_state_done", 32'(st), 4);
    check("seq_last_pc", 32'(pc), 9);
    tick(); tick();
    check("seq_done_held", 32'(done), 1);

    // Backpressure at pc=2, jump 3->7, self-loop at 8, then finish at 9.
    expect_fetch(0); expect_fetch(1); expect_fetch(2); expect_fetch(3);
    expect_fetch(7); expect_fetch(8); expect_fetch(8); expect_fetch(9);
    start = 1; tick(); start = 0;
    check("restart_done_cleared", {30'd0, done, fault}, 0);
    wait_hold(4'd2);
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(valid), 1);
      check("bp_instr", 32'(instr), 32'h102);
      check("bp_pc", 32'(pc), 2);
      check("bp_no_read", 32'(rd), 0);
    end
    ready = 1;
    wait_hold(4'd3);
    jump_en = 1; jump_addr = 4'd7;
    tick();
    jump_en = 0; jump_addr = 4'd0;
    check("jump_pointer", 32'(ptr), 7);
    check("jump_read", 32'(rd), 1);
    wait_hold(4'd8);
    jump_en = 1; jump_addr = 4'd8;
    tick();
    jump_en = 0; jump_addr = 4'd0;
    check("selfloop_pointer", 32'(ptr), 8);
    wait_done(n);
    check("jump_run_done", 32'(done), 1);
    check("jump_run_fault", 32'(fault), 0);
    check("jump_run_pc", 32'(pc), 9);

    // Illegal jump at pc=5, then restart.
    for (int k = 0; k < 6; k++) expect_fetch(k);
    start = 1; tick(); start = 0;
    check("ill_first_read", {27'd0, rd, ptr}, {27'd0, 1'b1, 4'd0});
    wait_hold(4'd5);
    jump_en = 1; jump_addr = 4'd12;
    tick();
    jump_en = 0; jump_addr = 4'd0;
    check("ill_done_fault", {30'd0, done, fault}, 3);
    check("ill_pc", 32'(pc), 5);
    check("ill_state", 32'(st), 4);
    check("ill_valid", 32'(valid), 0);
    tick(); tick(); tick();
    check("ill_no_read", 32'(rd), 0);
    for (int k = 0; k < 10; k++) expect_fetch(k);
    start = 1; tick(); start = 0;
    check("ill_restart_cleared", {30'd0, done, fault}, 0);
    check("ill_restart_pointer", 32'(ptr), 0);
    wait_done(n);
    check("ill_restart_done", {30'd0, done, fault}, 2);

    // Latency-3 instance: abort+start in IDLE, abort in WAIT, latency.
    abort_3 = 1; start_3 = 1; tick(); abort_3 = 0; start_3 = 0;
    check("l3_abort_start_idle", 32'(st_3), 0);
    start_3 = 1; tick(); start_3 = 0;
    check("l3_issue", {29'd0, st_3, rd_3} , {29'd0, 3'd1, 1'b1});
    tick();
    check("l3_wait", {29'd0, st_3, rd_3}, {29'd0, 3'd2, 1'b0});
    abort_3 = 1; tick(); abort_3 = 0;
    check("l3_abort_state", 32'(st_3), 0);
    tick(); tick(); tick(); tick();
    check("l3_abort_no_valid", 32'(valid_3), 0);
    start_3 = 1; tick(); start_3 = 0;
    tick();
    n = 0;
    while (!valid_3 && n < 10) begin
      tick();
      n++;
    end
    check("l3_capture_latency", 32'(n), 3);
    check("l3_instr", 32'(instr_3), 32'h100);
    check("l3_pc_state", {25'd0, pc_3, st_3}, {25'd0, 4'd0, 3'd3});

    tick(); tick();
    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("rd_q_empty", 32'(rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against any unbounded stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
